// File: rtl/enigma_pkg.sv
// Shared alphabet constants, rotor wiring tables and mod-N helpers for the Enigma rotor stage.
package enigma_pkg;

    localparam int N = 26;
    localparam int W = 5;

    typedef logic [W-1:0] letter_t;
    typedef logic [N-1:0][W-1:0] wiring_t;

    // Table 1 in 1-based letter form; converted to 0-based indices below.
    localparam int FWD_TABLE_1 [N] = '{6, 15, 11, 21, 4, 1, 26, 14, 17, 16, 24, 23, 2,
                                       10, 9, 5, 8, 3, 13, 19, 7, 12, 18, 25, 20, 22};

    function automatic wiring_t fwd_wiring(input int id);
        wiring_t w;
        for (int i = 0; i < N; i++) begin
            w[i] = (id == 1) ? W'(FWD_TABLE_1[i] - 1) : W'(i);
        end
        return w;
    endfunction

    function automatic wiring_t inv_wiring(input wiring_t f);
        wiring_t v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[f[i]] = W'(i);
        end
        return v;
    endfunction

    // Operands must already be in 0..N-1; one correction step keeps the result there.
    function automatic letter_t mod_add(input letter_t a, input letter_t b, input logic sub);
        logic [W:0] s;
        if (sub) begin
            s = {1'b0, a} - {1'b0, b};
            if (s[W]) s = s + (W+1)'(N);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= (W+1)'(N)) s = s - (W+1)'(N);
        end
        return s[W-1:0];
    endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// Combinational rotor core lookup: contact index c to wired contact m, forward or inverse by dir.
module enigma_rotor_map
    import enigma_pkg::*;
#(
    parameter int WIRING_ID = 1
) (
    input  logic         dir,
    input  logic [W-1:0] c,
    output logic [W-1:0] m
);

    localparam wiring_t FWD = fwd_wiring(WIRING_ID);
    localparam wiring_t INV = inv_wiring(FWD);

    assign m = dir ? INV[c] : FWD[c];

endmodule

// File: rtl/enigma_rotor_stage.sv
// Stateful Enigma rotor slot: odometer stepping with notch carry, one registered valid/ready letter stage.
// Optional historic middle-rotor double step is enabled by defining ENIGMA_DOUBLE_STEP_EN.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int N         = 26,
    parameter int W         = 5,
    parameter int WIRING_ID = 1,
    parameter int NOTCH     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_pos,
    input  logic [W-1:0] load_ring,
    input  logic         key_step,
    input  logic         carry_in,
    output logic         carry_out,
    output logic [W-1:0] pos,
    input  logic         dir,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_letter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_letter,
    output logic         err
);

    logic [W-1:0] ring;
    logic         advance;
    logic         at_notch;
    logic [W-1:0] pos_ld, ring_ld, pos_next;
    logic         bad;
    logic [W-1:0] in_idx, c_idx, m_idx, o_idx;

    assign at_notch = (pos == W'(NOTCH));

`ifdef ENIGMA_DOUBLE_STEP_EN
    // Middle rotor steps itself when sitting on its notch at a key press.
    assign advance = carry_in || (key_step && at_notch);
`else
    logic unused_key_step;
    assign unused_key_step = key_step;
    assign advance = carry_in;
`endif

    assign pos_ld   = (load_pos  >= W'(N)) ? load_pos  - W'(N) : load_pos;
    assign ring_ld  = (load_ring >= W'(N)) ? load_ring - W'(N) : load_ring;
    assign pos_next = (pos == W'(N-1)) ? '0 : pos + W'(1);

    assign in_ready = !out_valid || out_ready;

    always_comb begin
        bad    = (in_letter == '0) || (in_letter > W'(N));
        in_idx = bad ? '0 : in_letter - W'(1);
        c_idx  = mod_add(mod_add(in_idx, pos, 1'b0), ring, 1'b1);
        o_idx  = mod_add(mod_add(m_idx, ring, 1'b0), pos, 1'b1);
    end

    enigma_rotor_map #(.WIRING_ID(WIRING_ID)) u_map (
        .dir (dir),
        .c   (c_idx),
        .m   (m_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pos        <= '0;
            ring       <= '0;
            carry_out  <= 1'b0;
            out_valid  <= 1'b0;
            out_letter <= '0;
            err        <= 1'b0;
        end else begin
            if (load) begin
                pos       <= pos_ld;
                ring      <= ring_ld;
                carry_out <= 1'b0;
            end else if (advance) begin
                pos       <= pos_next;
                carry_out <= at_notch;
            end else begin
                carry_out <= 1'b0;
            end

            if (in_valid && in_ready) begin
                out_valid  <= 1'b1;
                out_letter <= bad ? '0 : o_idx + W'(1);
                err        <= bad;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
